// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with a start/in_ready and out_valid/out_ready handshake.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   output logic            in_ready,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam int CW = 6;
   localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_next;
   logic [CW-1:0]     counter;
   logic [2:0]        op;
   logic              neg;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] prod, prod_next, prod_neg, mul_sel;
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN-1:0]   div_diff, final_res;
   logic              div_ge;

   logic              a_signed, b_signed, a_neg, b_neg, neg_in;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   a_mag, b_mag, special_res;

   // Operand decode for the accept cycle
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      a_signed = (md_op == OP_MUL) || (md_op == OP_MULH) || (md_op == OP_MULHSU) ||
                 (md_op == OP_DIV) || (md_op == OP_REM);
      b_signed = (md_op == OP_MUL) || (md_op == OP_MULH) ||
                 (md_op == OP_DIV) || (md_op == OP_REM);
      a_neg    = a_signed & rs1_data[XLEN-1];
      b_neg    = b_signed & rs2_data[XLEN-1];
      a_mag    = a_neg ? -rs1_data : rs1_data;
      b_mag    = b_neg ? -rs2_data : rs2_data;
      neg_in   = (md_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
      div_zero = md_op[2] && (rs2_data == '0);
      div_ovf  = ((md_op == OP_DIV) || (md_op == OP_REM)) &&
                 (rs1_data == MIN_INT) && (rs2_data == '1);
      special  = div_zero | div_ovf;
      special_res = '0;
      if (md_op[1]) special_res = div_zero ? rs1_data : '0;
      else          special_res = div_zero ? '1 : MIN_INT;
   end

   // One iteration: prod holds {partial, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
      div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      div_diff  = div_shift[XLEN-1:0] - opnd;
      div_ge    = div_shift >= {1'b0, opnd};
      if (op[2])
         prod_next = {(div_ge ? div_diff : div_shift[XLEN-1:0]), prod[XLEN-2:0], div_ge};
      else
         prod_next = {mul_sum, prod[XLEN-1:1]};
   end

   always_comb begin
      prod_neg  = -prod_next;
      mul_sel   = neg ? prod_neg : prod_next;
      final_res = mul_sel[XLEN-1:0];
      case (op)
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_sel[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU: final_res = neg ? -prod_next[XLEN-1:0] : prod_next[XLEN-1:0];
         OP_REM, OP_REMU: final_res = neg ? -prod_next[2*XLEN-1:XLEN] : prod_next[2*XLEN-1:XLEN];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) state_next = IDLE;
      else begin
         case (state)
            IDLE: if (start) state_next = special ? DONE : CALC;
            CALC: if (counter == LAST) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: datapath registers are reset as well, so result reads zero straight out of reset.
      if (!reset_n) begin
         counter <= '0;
         op      <= OP_MUL;
         neg     <= 1'b0;
         opnd    <= '0;
         prod    <= '0;
         result  <= '0;
      end else if (flush) begin
         counter <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op      <= md_op;
               neg     <= neg_in;
               counter <= '0;
               if (md_op[2]) begin
                  opnd <= b_mag;
                  prod <= {{XLEN{1'b0}}, a_mag};
               end else begin
                  opnd <= a_mag;
                  prod <= {{XLEN{1'b0}}, b_mag};
               end
               if (special) result <= special_res;
            end
            CALC: begin
               prod <= prod_next;
               if (counter == LAST) begin
                  counter <= '0;
                  result  <= final_res;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
